// File: rtl/fifo_byte_unpacker_pkg.sv
// Shared definitions for the FIFO drain-side byte unpacker: word field offsets,
// FSM state encoding and the payload byte selector.
package fifo_byte_unpacker_pkg;

   localparam int unsigned WORD_W     = 140;
   localparam int unsigned CHAN_HI    = 139;
   localparam int unsigned CHAN_LO    = 136;
   localparam int unsigned RSVD_HI    = 135;
   localparam int unsigned RSVD_LO    = 132;
   localparam int unsigned LEN_HI     = 131;
   localparam int unsigned LEN_LO     = 128;
   localparam int unsigned PAYLOAD_HI = 127;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StSend = 2'd2
   } state_e;

   // 16:1 byte mux over the 128-bit payload; byte k lives at [8k+7:8k].
   function automatic logic [7:0] sel_byte(input logic [PAYLOAD_HI:0] payload,
                                           input logic [3:0] idx);
      return payload[{idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/fifo_byte_unpacker.sv
// Pops framed 140-bit records from the read side of the clock-crossing FIFO and
// streams their valid payload bytes one per cycle on a valid/ready interface.
module fifo_byte_unpacker #(
   parameter int unsigned WORD_W        = fifo_byte_unpacker_pkg::WORD_W,
   parameter int unsigned PAYLOAD_BYTES = 16,
   parameter int unsigned CNT_W         = 16
) (
   input  logic              clk_out,
   input  logic              rst_n,
   input  logic              fifo_empty,
   output logic              fifo_r_enable,
   input  logic [WORD_W-1:0] data_from_fifo,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic [7:0]        byte_data,
   output logic              byte_last,
   output logic [3:0]        byte_chan,
   output logic [CNT_W-1:0]  word_cnt,
   output logic              err_rsvd
);
   import fifo_byte_unpacker_pkg::*;

   localparam int unsigned IDX_W = $clog2(PAYLOAD_BYTES);

   state_e              state;
   logic [PAYLOAD_HI:0] payload_q;
   logic [IDX_W-1:0]    len_q;
   logic [IDX_W-1:0]    idx_q;
   logic [IDX_W-1:0]    idx_next;
   logic                handshake;

   always_comb begin
      idx_next  = idx_q + 1'b1;
      handshake = byte_valid && byte_ready;
   end

   // The prefetch pop on the last handshake hides the FIFO read latency behind SEND.
   always_comb begin
      fifo_r_enable = !fifo_empty &&
                      ((state == StIdle) ||
                       (state == StSend && handshake && byte_last));
   end

   always_ff @(posedge clk_out or negedge rst_n) begin
      if (!rst_n) begin
         state      <= StIdle;
         payload_q  <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         byte_valid <= 1'b0;
         byte_data  <= 8'h00;
         byte_last  <= 1'b0;
         byte_chan  <= 4'h0;
         word_cnt   <= '0;
         err_rsvd   <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (!fifo_empty) begin
                  state <= StWait;
               end
            end
            StWait: begin
               payload_q  <= data_from_fifo[PAYLOAD_HI:0];
               len_q      <= data_from_fifo[LEN_HI:LEN_LO];
               idx_q      <= '0;
               word_cnt   <= word_cnt + 1'b1;
               if (data_from_fifo[RSVD_HI:RSVD_LO] != 4'h0) begin
                  err_rsvd <= 1'b1;
               end
               byte_valid <= 1'b1;
               byte_data  <= data_from_fifo[7:0];
               byte_chan  <= data_from_fifo[CHAN_HI:CHAN_LO];
               byte_last  <= (data_from_fifo[LEN_HI:LEN_LO] == 4'h0);
               state      <= StSend;
            end
            StSend: begin
               if (handshake) begin
                  if (!byte_last) begin
                     idx_q     <= idx_next;
                     byte_data <= sel_byte(payload_q, idx_next);
                     byte_last <= (idx_next == len_q);
                  end else begin
                     byte_valid <= 1'b0;
                     state      <= fifo_empty ? StIdle : StWait;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_byte_unpacker.sv
// Self-checking bench: behavioural FIFO read port with 1-cycle read data,
// scoreboard of expected bytes, directed scenarios for timing, flags and reset.
module tb_fifo_byte_unpacker;

   logic         clk_out = 1'b0;
   logic         rst_n   = 1'b0;
   logic         fifo_empty;
   logic         fifo_r_enable;
   logic [139:0] data_from_fifo;
   logic         byte_valid;
   logic         byte_ready = 1'b0;
   logic [7:0]   byte_data;
   logic         byte_last;
   logic [3:0]   byte_chan;
   logic [15:0]  word_cnt;
   logic         err_rsvd;

   fifo_byte_unpacker #(
      .WORD_W       (140),
      .PAYLOAD_BYTES(16),
      .CNT_W        (16)
   ) dut (
      .clk_out       (clk_out),
      .rst_n         (rst_n),
      .fifo_empty    (fifo_empty),
      .fifo_r_enable (fifo_r_enable),
      .data_from_fifo(data_from_fifo),
      .byte_valid    (byte_valid),
      .byte_ready    (byte_ready),
      .byte_data     (byte_data),
      .byte_last     (byte_last),
      .byte_chan     (byte_chan),
      .word_cnt      (word_cnt),
      .err_rsvd      (err_rsvd)
   );

   always #5 clk_out = ~clk_out;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // FIFO model, scoreboard and cycle bookkeeping
   logic [139:0] fifo_q[$];
   logic [12:0]  exp_q[$];
   int           pop_log[$];
   int           last_log[$];
   int           cyc = 0;
   int           pop_cnt = 0;
   int           hs_cnt = 0;
   int           exp_wcnt = 0;
   int           ready_mode = 0;
   int           rphase = 0;

   always @(posedge clk_out or negedge rst_n) begin
      if (!rst_n) begin
         data_from_fifo <= '0;
         fifo_empty     <= 1'b1;
      end else begin
         if (fifo_r_enable && fifo_q.size() > 0) begin
            data_from_fifo <= fifo_q.pop_front();
            pop_log.push_back(cyc);
            pop_cnt++;
         end
         fifo_empty <= (fifo_q.size() == 0);
         cyc++;
      end
   end

   // byte_ready changes just after the active edge so it is stable at the next one
   initial begin
      forever begin
         @(posedge clk_out);
         #2;
         if (ready_mode == 0) begin
            byte_ready = 1'b1;
         end else begin
            byte_ready = (rphase == 0);
            rphase     = (rphase + 1) % 3;
         end
      end
   end

   logic        stall = 1'b0;
   logic [12:0] stall_val = '0;

   always @(negedge clk_out) begin
      logic [12:0] obs;
      logic [12:0] e;
      obs = {byte_last, byte_chan, byte_data};
      if (!rst_n) begin
         stall = 1'b0;
      end else begin
         if (fifo_empty) check("pop_while_empty", 32'(fifo_r_enable), 32'd0);
         if (stall) begin
            check("stall_valid", 32'(byte_valid), 32'd1);
            check("stall_hold", 32'(obs), 32'(stall_val));
         end
         if (byte_valid && byte_ready) begin
            check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("byte", 32'(obs), 32'(e));
            end
            hs_cnt++;
            if (byte_last) last_log.push_back(cyc);
         end
         stall     = byte_valid && !byte_ready;
         stall_val = obs;
      end
   end

   task automatic push_word(input logic [3:0] chan, input logic [3:0] rsvd,
                            input logic [3:0] len_m1, input logic [127:0] payload);
      fifo_q.push_back({chan, rsvd, len_m1, payload});
      for (int k = 0; k <= int'(len_m1); k++) begin
         exp_q.push_back({(k == int'(len_m1)), chan, payload[k*8 +: 8]});
      end
      exp_wcnt++;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || fifo_q.size() != 0 || byte_valid) && n < budget) begin
         @(negedge clk_out);
         n++;
      end
      check("drain_timeout", 32'(n < budget), 32'd1);
   endtask

   task automatic clear_logs();
      pop_log.delete();
      last_log.delete();
      pop_cnt = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, n_cmp=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n;
      logic [127:0] p;

      #23;
      check("rst_valid", 32'(byte_valid), 32'd0);
      check("rst_data", 32'(byte_data), 32'd0);
      check("rst_wcnt", 32'(word_cnt), 32'd0);
      check("rst_err", 32'(err_rsvd), 32'd0);
      check("rst_pop", 32'(fifo_r_enable), 32'd0);
      @(negedge clk_out);
      rst_n = 1'b1;
      repeat (3) @(negedge clk_out);

      // Single 3-byte word
      clear_logs();
      push_word(4'h3, 4'h0, 4'd2, 128'h0000_0000_0000_0000_0000_0000_00C3_B2A1);
      wait_drain(50);
      check("single_pops", 32'(pop_cnt), 32'd1);
      check("single_wcnt", 32'(word_cnt), 32'(exp_wcnt));
      check("single_lat", 32'(last_log.size() == 1 ? last_log[0] - pop_log[0] : -1), 32'd4);

      // Back-to-back prefetch: 1-byte word then 16-byte word
      clear_logs();
      push_word(4'h1, 4'h0, 4'd0, 128'h55);
      p = {$urandom, $urandom, $urandom, $urandom};
      push_word(4'hA, 4'h0, 4'd15, p);
      wait_drain(80);
      check("b2b_pops", 32'(pop_log.size()), 32'd2);
      if (pop_log.size() == 2 && last_log.size() == 2) begin
         check("b2b_prefetch", 32'(pop_log[1]), 32'(last_log[0]));
         check("b2b_total", 32'(last_log[1] - pop_log[0]), 32'd19);
      end else begin
         check("b2b_logs", 32'(last_log.size()), 32'd2);
      end
      check("b2b_wcnt", 32'(word_cnt), 32'(exp_wcnt));

      // Backpressure with ready pattern 1,0,0
      ready_mode = 1;
      rphase     = 0;
      base       = hs_cnt;
      push_word(4'h7, 4'h0, 4'd3, 128'h4433_2211);
      wait_drain(100);
      check("bp_handshakes", 32'(hs_cnt - base), 32'd4);
      ready_mode = 0;

      // Reserved-field flag is sticky
      check("rsvd_clear", 32'(err_rsvd), 32'd0);
      push_word(4'h2, 4'h5, 4'd0, 128'h9E);
      n = 0;
      while (!byte_valid && n < 20) begin
         @(negedge clk_out);
         n++;
      end
      check("rsvd_send_timeout", 32'(n < 20), 32'd1);
      check("rsvd_set", 32'(err_rsvd), 32'd1);
      wait_drain(50);
      for (int i = 0; i < 10; i++) begin
         push_word(4'(i), 4'h0, 4'($urandom_range(0, 15)),
                   {$urandom, $urandom, $urandom, $urandom});
      end
      wait_drain(400);
      check("rsvd_sticky", 32'(err_rsvd), 32'd1);
      check("rsvd_wcnt", 32'(word_cnt), 32'(exp_wcnt));

      // Empty FIFO for 50 cycles
      repeat (50) begin
         @(negedge clk_out);
         check("empty_valid", 32'(byte_valid), 32'd0);
         check("empty_pop", 32'(fifo_r_enable), 32'd0);
      end

      // Reset in the middle of a 16-byte word
      base = hs_cnt;
      push_word(4'hC, 4'h0, 4'd15, {$urandom, $urandom, $urandom, $urandom});
      n = 0;
      while (hs_cnt < base + 2 && n < 30) begin
         @(negedge clk_out);
         n++;
      end
      check("midword_timeout", 32'(n < 30), 32'd1);
      #1;
      rst_n = 1'b0;
      fifo_q.delete();
      exp_q.delete();
      exp_wcnt = 0;
      #1;
      check("arst_valid", 32'(byte_valid), 32'd0);
      check("arst_data", 32'(byte_data), 32'd0);
      check("arst_last", 32'(byte_last), 32'd0);
      check("arst_chan", 32'(byte_chan), 32'd0);
      check("arst_wcnt", 32'(word_cnt), 32'd0);
      check("arst_err", 32'(err_rsvd), 32'd0);
      check("arst_pop", 32'(fifo_r_enable), 32'd0);
      repeat (2) @(negedge clk_out);
      rst_n = 1'b1;
      repeat (2) @(negedge clk_out);
      push_word(4'h6, 4'h0, 4'd5, 128'h665544332211);
      wait_drain(50);
      check("post_rst_wcnt", 32'(word_cnt), 32'd1);

      repeat (3) @(negedge clk_out);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
